// File: rtl/core_trace_uart.sv
// Trace capture for the RV32 core: buffers debug snapshots in a small frame FIFO
// and sends each one as a 12-byte 8N1 UART packet starting with sync byte 0xA5.
module core_trace_uart #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        sample_i,
    input  logic [4:0]  reg_address_i,
    input  logic [15:0] mem_address_i,
    input  logic [31:0] reg_data_i,
    input  logic [31:0] mem_data_i,
    output logic        tx_o,
    output logic        busy_o,
    output logic        fifo_full_o,
    output logic [7:0]  drop_count_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned FW = 85;
    localparam int unsigned SW = 96;
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BYTE = 4'd11;
    localparam logic [2:0]    LAST_BIT  = 3'd7;
    localparam logic [7:0]    SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_e;

    logic [FW-1:0] mem_q [FIFO_DEPTH];
    logic [FW-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic [7:0]    drop_q, drop_d;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    byte_q, byte_d;
    logic [SW-1:0] shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;

    logic          empty_c;
    logic          wr_en_c;
    logic          pop_c;
    logic          cnt_last_c;
    logic [7:0]    cur_byte;

    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign wr_en_c    = sample_i && !full_q;
    assign pop_c      = (state_q == LOAD);
    assign cnt_last_c = (cnt_q == CNT_LAST);

    // Frame FIFO: admission is judged on the registered full flag only.
    always_comb begin : fifo_next
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        drop_d   = drop_q;
        if (wr_en_c) begin
            mem_d[wr_ptr_q[AW-1:0]] = {reg_address_i, mem_address_i, reg_data_i, mem_data_i};
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (sample_i && full_q && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    // Serialiser: bytes of a frame go out back to back, MSB byte first, LSB bit first.
    always_comb begin : ser_next
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        cur_byte = 8'h00;

        case (state_q)
            IDLE: begin
                if (!empty_c) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shift_d = {SYNC_BYTE, 3'b000, mem_q[rd_ptr_q[AW-1:0]]};
                byte_d  = 4'd0;
                bit_d   = 3'd0;
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (cnt_last_c) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_last_c) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_last_c) begin
                    cnt_d = '0;
                    if (byte_q != LAST_BYTE) begin
                        shift_d = {shift_q[SW-9:0], 8'h00};
                        byte_d  = byte_q + 4'd1;
                        state_d = START;
                    end else if (!empty_c) begin
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so it lines up with that state.
        cur_byte = shift_d[SW-1 -: 8];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin : ctrl_regs
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            drop_q   <= 8'h00;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            byte_q   <= 4'd0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // Storage needs no reset; occupancy is defined entirely by the pointers.
    always_ff @(posedge clk_i) begin : fifo_mem
        mem_q <= mem_d;
    end

    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign fifo_full_o  = full_q;
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_core_trace_uart.sv
// Bench for core_trace_uart: queue-based frame/line model checked every cycle,
// a UART receiver for decoded bytes, and directed plus random stimulus.
module tb_core_trace_uart;
    localparam int CPB       = 4;
    localparam int DEPTH     = 4;
    localparam int FRAME_CYC = 120 * CPB;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        sample_i;
    logic [4:0]  reg_address;
    logic [15:0] mem_address;
    logic [31:0] reg_data;
    logic [31:0] mem_data;
    logic        tx_o;
    logic        busy_o;
    logic        fifo_full_o;
    logic [7:0]  drop_count_o;

    core_trace_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .sample_i     (sample_i),
        .reg_address_i(reg_address),
        .mem_address_i(mem_address),
        .reg_data_i   (reg_data),
        .mem_data_i   (mem_data),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .fifo_full_o  (fifo_full_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Model: queued frames, and the exact future line levels of the frame in flight.
    logic [84:0] mq[$];
    bit          stream[$];
    bit          m_full   = 1'b0;
    int          m_drops  = 0;
    bit          load_now = 1'b0;

    logic [7:0]  rx_byte_q[$];
    int          rx_cyc_q[$];

    function automatic logic [95:0] frame_bytes(input logic [84:0] f);
        return {8'hA5, 3'b000, f};
    endfunction

    function automatic logic [84:0] rand_frame();
        return {5'($urandom), 16'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    always @(posedge clk) begin : model
        int          cnt;
        logic [84:0] head;
        bit          was_load;
        logic [95:0] fb;
        logic [7:0]  bv;
        cyc++;
        if (reset_i) begin
            mq.delete();
            stream.delete();
            m_full   = 1'b0;
            m_drops  = 0;
            load_now = 1'b0;
        end else begin
            cnt      = mq.size();
            head     = (cnt > 0) ? mq[0] : '0;
            was_load = load_now;
            load_now = 1'b0;
            if (was_load) void'(mq.pop_front());
            if (sample_i) begin
                if (m_full) begin
                    if (m_drops < 255) m_drops++;
                end else begin
                    mq.push_back({reg_address, mem_address, reg_data, mem_data});
                end
            end
            m_full = (mq.size() == DEPTH);
            if (stream.size() > 0) void'(stream.pop_front());
            if (stream.size() == 0 && cnt > 0) begin
                fb = frame_bytes(head);
                stream.push_back(1'b1);
                for (int k = 0; k < 12; k++) begin
                    bv = fb[95 - 8*k -: 8];
                    for (int j = 0; j < 10; j++)
                        for (int r = 0; r < CPB; r++)
                            stream.push_back((j == 0) ? 1'b0 : ((j == 9) ? 1'b1 : bv[j-1]));
                end
                load_now = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tx"},   32'(tx_o), 32'd1);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_full"}, 32'(fifo_full_o), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count_o), 32'd0);
    endtask

    task automatic set_frame(input logic [84:0] f);
        {reg_address, mem_address, reg_data, mem_data} = f;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy_o !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_bound", 32'(busy_o), 32'd0);
    endtask

    task automatic chk_rx_frame(input int idx, input logic [84:0] f);
        logic [95:0] fb;
        fb = frame_bytes(f);
        for (int k = 0; k < 12; k++) begin
            if (idx*12 + k < rx_byte_q.size())
                chk($sformatf("rx_f%0d_b%0d", idx, k), 32'(rx_byte_q[idx*12 + k]), 32'(fb[95 - 8*k -: 8]));
            else
                chk($sformatf("rx_f%0d_b%0d_missing", idx, k), 32'(rx_byte_q.size()), 32'(idx*12 + k + 1));
        end
    endtask

    task automatic rx_clear();
        rx_byte_q.delete();
        rx_cyc_q.delete();
    endtask

    initial begin
        logic [84:0] ov [7];
        logic [84:0] f1, f2;
        logic [7:0]  exp1 [12];
        int          n0;
        int          zeros;

        exp1 = '{8'hA5, 8'h1F, 8'h12, 8'h34, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'hFF};
        reset_i  = 1'b1;
        sample_i = 1'b1;
        set_frame(rand_frame());

        fork
            begin : watchdog
                #1_000_000;
                $display("FAIL watchdog: simulation exceeded its time limit");
                $fatal(1);
            end
            begin : compare
                forever begin
                    @(negedge clk);
                    if (chk_en) begin
                        chk("model_tx", 32'(tx_o), (stream.size() > 0) ? 32'(stream[0]) : 32'd1);
                        chk("model_busy", 32'(busy_o), 32'(stream.size() > 0));
                        chk("model_full", 32'(fifo_full_o), 32'(m_full));
                        chk("model_drop", 32'(drop_count_o), 32'(m_drops));
                    end
                end
            end
            begin : receiver
                forever begin
                    @(negedge clk);
                    if (chk_en && tx_o === 1'b0) begin
                        logic [7:0] b;
                        int         st;
                        st = cyc;
                        b  = 8'h00;
                        repeat (CPB + CPB/2) @(negedge clk);
                        for (int i = 0; i < 8; i++) begin
                            b[i] = tx_o;
                            repeat (CPB) @(negedge clk);
                        end
                        rx_byte_q.push_back(b);
                        rx_cyc_q.push_back(st);
                    end
                end
            end
        join_none

        // Reset held two cycles with sample_i high
        @(negedge clk);
        chk_en = 1'b1;
        chk_reset_vals("reset_c1");
        @(negedge clk);
        chk_reset_vals("reset_c2");
        reset_i  = 1'b0;
        sample_i = 1'b0;
        step(5);
        chk("reset_no_frame_busy", 32'(busy_o), 32'd0);
        chk("reset_no_frame_tx", 32'(tx_o), 32'd1);

        // Single frame with known contents
        rx_clear();
        @(negedge clk);
        sample_i = 1'b1;
        set_frame({5'h1F, 16'h1234, 32'hDEADBEEF, 32'h000000FF});
        n0 = cyc;
        @(negedge clk);
        sample_i = 1'b0;
        chk("single_busy_n1", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("single_tx_n2", 32'(tx_o), 32'd1);
        chk("single_busy_n2", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("single_start_n3", 32'(tx_o), 32'd0);
        wait_idle(FRAME_CYC + 20);
        chk("single_busy_fall", 32'(cyc - n0), 32'd483);
        chk("single_rx_count", 32'(rx_byte_q.size()), 32'd12);
        if (rx_cyc_q.size() > 0) chk("single_start_cycle", 32'(rx_cyc_q[0] - n0), 32'd3);
        else chk("single_start_cycle_missing", 32'(rx_cyc_q.size()), 32'd1);
        for (int k = 0; k < 12; k++) begin
            if (k < rx_byte_q.size()) chk($sformatf("single_b%0d", k), 32'(rx_byte_q[k]), 32'(exp1[k]));
        end

        // Back-to-back samples
        rx_clear();
        f1 = rand_frame();
        f2 = rand_frame();
        @(negedge clk);
        sample_i = 1'b1;
        set_frame(f1);
        @(negedge clk);
        set_frame(f2);
        @(negedge clk);
        sample_i = 1'b0;
        wait_idle(2 * (FRAME_CYC + 1) + 50);
        chk("b2b_rx_count", 32'(rx_byte_q.size()), 32'd24);
        chk_rx_frame(0, f1);
        chk_rx_frame(1, f2);
        if (rx_cyc_q.size() >= 13) chk("b2b_gap", 32'(rx_cyc_q[12] - rx_cyc_q[11]), 32'(10*CPB + 1));
        else chk("b2b_gap_missing", 32'(rx_cyc_q.size()), 32'd13);

        // Overflow: seven consecutive samples into a depth-4 FIFO
        rx_clear();
        for (int k = 0; k < 7; k++) ov[k] = rand_frame();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            sample_i = 1'b1;
            set_frame(ov[k]);
            if (k == 4) chk("ovf_full_n4", 32'(fifo_full_o), 32'd0);
            if (k == 5) chk("ovf_full_n5", 32'(fifo_full_o), 32'd1);
        end
        @(negedge clk);
        sample_i = 1'b0;
        chk("ovf_drops", 32'(drop_count_o), 32'd2);
        wait_idle(6 * (FRAME_CYC + 1) + 50);
        chk("ovf_rx_count", 32'(rx_byte_q.size()), 32'd60);
        for (int f = 0; f < 5; f++) chk_rx_frame(f, ov[f]);
        step(10);
        chk("ovf_no_sixth", 32'(busy_o), 32'd0);

        // Drop counter saturation
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            sample_i = 1'b1;
            set_frame(rand_frame());
        end
        @(negedge clk);
        chk("sat_drop_255", 32'(drop_count_o), 32'd255);
        step(20);
        chk("sat_drop_hold", 32'(drop_count_o), 32'd255);
        sample_i = 1'b0;
        reset_i  = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk_reset_vals("sat_reset");
        step(3);
        chk("sat_queue_lost", 32'(busy_o), 32'd0);

        // Reset during byte 3 of a frame
        @(negedge clk);
        sample_i = 1'b1;
        set_frame(rand_frame());
        @(negedge clk);
        sample_i = 1'b0;
        step(2);
        chk("mid_start", 32'(tx_o), 32'd0);
        step(3*10*CPB + CPB + 2);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk_reset_vals("mid_reset");
        zeros = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) zeros++;
        end
        chk("mid_no_more_bits", 32'(zeros), 32'd0);
        rx_clear();
        f2 = rand_frame();
        @(negedge clk);
        sample_i = 1'b1;
        set_frame(f2);
        @(negedge clk);
        sample_i = 1'b0;
        step(2);
        wait_idle(FRAME_CYC + 20);
        chk("mid_rx_count", 32'(rx_byte_q.size()), 32'd12);
        if (rx_byte_q.size() > 0) chk("mid_sync", 32'(rx_byte_q[0]), 32'hA5);
        chk_rx_frame(0, f2);

        // Random traffic with occasional resets, checked by the model each cycle
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            sample_i = ($urandom_range(0, 99) < 2);
            reset_i  = ($urandom_range(0, 1999) == 0);
            set_frame(rand_frame());
        end
        @(negedge clk);
        sample_i = 1'b0;
        reset_i  = 1'b0;
        step(3);
        wait_idle(6 * (FRAME_CYC + 1) + 50);
        step(5);
        chk("rand_final_tx", 32'(tx_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_trace_uart.md
# core_trace_uart

Downstream trace stage for the single-cycle RV32 core. It captures the core's debug outputs (source register address, data-memory address, register read data and memory read data) on a sample strobe. Each capture is buffered as one frame in a small FIFO and serialised as a fixed 12-byte packet on a UART 8N1 transmit line, so instruction-level activity can be logged on a board without a debugger.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- FIFO_DEPTH, default 4: frame FIFO depth; power of two, ≥ 2.

- clk_i  input  1  core clock; all logic rising-edge.
- reset_i  input  1  synchronous, active-high reset; one clock, same as the core.
- sample_i  input  1  capture strobe; one frame per cycle it is high.
- reg_address_i  input  5  core reg_address_o.
- mem_address_i  input  16  core mem_address_o.
- reg_data_i  input  32  core reg_data_o.
- mem_data_i  input  32  core mem_data_o.
- tx_o  output  1  UART serial out; idle high.
- busy_o  output  1  high whenever the serialiser state is not IDLE.
- fifo_full_o  output  1  registered FIFO-full flag.
- drop_count_o  output  8  frames discarded because the FIFO was full; saturates at 255.

## Operation
- Frame format, byte order on the wire:
  - 0xA5 sync byte.
  - {3'b000, reg_address}.
  - mem_address, MSB byte first (2 bytes).
  - reg_data, MSB byte first (4 bytes).
  - mem_data, MSB byte first (4 bytes).
  - 12 bytes in total. The FIFO stores the 85 captured bits; sync byte and pad are inserted at load.
- Capture: when sample_i is high and fifo_full_o is low, the inputs are written at that clock edge.
  - When sample_i is high and fifo_full_o is high, the frame is dropped and drop_count_o increments, saturating at 255.
  - Full is evaluated on the registered flag, so a pop in the same cycle does not admit the write.
- Serialiser FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE → LOAD when the FIFO is non-empty.
  - LOAD, one cycle, tx_o high: pops the FIFO head into a 96-bit shift register, clears the byte index → START.
  - START: tx_o=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each → STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles; then:
    - byte index < 11: shift 8, index+1 → START, so bytes within a frame are contiguous;
    - byte index = 11 and FIFO non-empty → LOAD;
    - otherwise → IDLE.
- Simultaneous write and pop in one cycle: occupancy is unchanged and both operations take effect.
- Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full means the MSBs differ and the rest are equal.

## Timing
- Reset values:
  - tx_o=1, busy_o=0, fifo_full_o=0, drop_count_o=0.
  - FSM in IDLE; FIFO emptied; bit counter, byte index and shift register cleared.
- Latency: sample_i high in cycle N with the FIFO empty and FSM idle gives:
  - IDLE detects non-empty in N+1;
  - LOAD in N+2;
  - start bit on tx_o from N+3.
- Frame duration is 120×CLKS_PER_BIT cycles. Consecutive frames are separated by exactly one idle-high cycle (LOAD).
- busy_o goes high in N+2 and low in the cycle after the final STOP when the FIFO is empty.
- Reset mid-frame takes effect at the next edge:
  - tx_o is high from the following cycle;
  - queued frames are lost and drop_count_o is cleared;
  - no partial byte resumes afterwards.
- Sustained throughput is below one frame per instruction. Drops are expected and counted, never back-pressured onto the core.

## Test plan
- Reset: hold reset_i 2 cycles with sample_i=1 → tx_o=1, busy_o=0, fifo_full_o=0, drop_count_o=0 throughout, no frame queued.
- Single frame, CLKS_PER_BIT=4: sample in cycle N with reg_address=5'h1F, mem_address=16'h1234, reg_data=32'hDEADBEEF, mem_data=32'h000000FF.
  - Start bit at N+3.
  - Decoded bytes: A5 1F 12 34 DE AD BE EF 00 00 00 FF.
  - 480 cycles of activity, then busy_o=0.
- Back-to-back: samples in N and N+1 → two correct frames with exactly one tx_o=1 cycle between the last stop bit and the second start bit.
- Overflow, FIFO_DEPTH=4: sample_i high for cycles N..N+6 with distinct data.
  - fifo_full_o rises after edge N+4.
  - drop_count_o=2.
  - Exactly 5 frames are transmitted, in order: samples 0–4.
- Saturation: keep the FIFO full and assert sample_i for 300 cycles → drop_count_o reaches 255 and holds.
- Reset mid-frame: assert reset_i during byte 3 of a frame.
  - tx_o is high the next cycle; no further bits are sent.
  - A later sample produces a clean frame starting with 0xA5.
